alu_arbiter: RTL

- Shares the single 16-bit ALU between two requesters.
  - Requester 0 is the pipeline EX stage.
  - Requester 1 is an auxiliary unit, e.g. an address generator or a debug port.
- Uses valid/ready handshakes, grants one operation per cycle and returns a registered result one cycle after the grant.
- Owns the NVZ flag register; only requester-0 operations may update flags, so auxiliary traffic never corrupts branch conditions.

---
 rtl/alu_arbiter_pkg.sv | 21 ++
 rtl/alu_arbiter_flag_update.sv | 31 +++
 rtl/alu_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: opcode encodings, NVZ flag bit positions
// and default widths.
package alu_arbiter_pkg;

   localparam int DW_DEF       = 16;
   localparam int OPW_DEF      = 4;
   localparam int MAX_WAIT_DEF = 4;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_SLL = 4'h5;
   localparam logic [3:0] OP_SRL = 4'h6;

   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

endpackage

// File: rtl/alu_arbiter_flag_update.sv
// Next-state logic for the NVZ flag register; flags move only when en is high
// and only for the opcodes that define them.
module alu_flag_update
   import alu_arbiter_pkg::*;
#(
   parameter int DW  = DW_DEF,
   parameter int OPW = OPW_DEF
) (
   input  logic [OPW-1:0] op,
   input  logic [DW-1:0]  alu_out,
   input  logic           alu_err,
   input  logic           en,
   input  logic [2:0]     flag_q,
   output logic [2:0]     flag_d
);

   always_comb begin
      flag_d = flag_q;
      if (en) begin
         if (op == OPW'(OP_ADD) || op == OPW'(OP_SUB)) begin
            flag_d[FLAG_N] = alu_out[DW-1];
            flag_d[FLAG_V] = alu_err;
         end
         // Z is defined for the whole arithmetic/logic group, ADD through SRL.
         if (op <= OPW'(OP_SRL)) begin
            flag_d[FLAG_Z] = (alu_out == '0);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU, owning the NVZ flags.
// Build option ALU_ARB_PIPE_PRIO_EN: requester 0 priority with a starvation guard.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int OPW      = OPW_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [OPW-1:0] req0_op,
   input  logic [DW-1:0]  req0_a,
   input  logic [DW-1:0]  req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [OPW-1:0] req1_op,
   input  logic [DW-1:0]  req1_a,
   input  logic [DW-1:0]  req1_b,
   output logic [DW-1:0]  alu_in1,
   output logic [DW-1:0]  alu_in2,
   output logic [OPW-1:0] alu_op,
   input  logic [DW-1:0]  alu_out,
   input  logic           alu_err,
   output logic           rsp0_valid,
   output logic           rsp1_valid,
   output logic [DW-1:0]  rsp_data,
   output logic [2:0]     flag_out
);

   // Handshake: a transfer happens when reqN_valid && reqN_ready in the same cycle;
   // ready is the combinational grant, and the response pulses exactly one cycle later.
   logic       grant0;
   logic       grant1;
   logic       last_grant;
   logic [2:0] flag_q;
   logic [2:0] flag_d;

`ifdef ALU_ARB_PIPE_PRIO_EN
   localparam int WCW = $clog2(MAX_WAIT + 1);
   logic [WCW-1:0] wait_cnt;
   logic           starved;

   assign starved = (wait_cnt == WCW'(MAX_WAIT));

   always_comb begin
      grant0 = rst && req0_valid && !(req1_valid && starved);
      grant1 = rst && req1_valid && !grant0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt <= '0;
      end else if (!req1_valid || grant1) begin
         wait_cnt <= '0;
      end else if (!starved) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end
`else
   // On a tie the requester that did not win last time goes first.
   always_comb begin
      grant0 = rst && req0_valid && !(req1_valid && !last_grant);
      grant1 = rst && req1_valid && !grant0;
   end
`endif

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      alu_op  = grant1 ? req1_op : req0_op;
      alu_in1 = grant1 ? req1_a  : req0_a;
      alu_in2 = grant1 ? req1_b  : req0_b;
   end

   alu_flag_update #(
      .DW  (DW),
      .OPW (OPW)
   ) u_flag_update (
      .op      (alu_op),
      .alu_out (alu_out),
      .alu_err (alu_err),
      .en      (grant0),
      .flag_q  (flag_q),
      .flag_d  (flag_d)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp_data   <= '0;
         flag_q     <= '0;
         last_grant <= 1'b1;
      end else begin
         rsp0_valid <= grant0;
         rsp1_valid <= grant1;
         flag_q     <= flag_d;
         if (grant0 || grant1) begin
            rsp_data   <= alu_out;
            last_grant <= grant1;
         end
      end
   end

   assign flag_out = flag_q;

endmodule
